q_update: RTL and testbench

- Writer side of the Q table that the policy generator reads.
- After a move, it takes (state, action, reward, next_state, terminal) and reads Q(s,a).
- It then scans Q(s',0..8) to find the maximum and computes the TD update with shift-based alpha/gamma.
- It writes the saturated result back to Q(s,a) through the Q-table memory port.
- It sits between the game controller and the Q-table RAM, and is time-multiplexed with the policy read path by the controller.

---
 rtl/q_update.sv | 183 ++++++++++++++++++
 tb/tb_q_update.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_update.sv
// Q-table writer: reads Q(s,a), scans Q(s',0..N-1) for its signed maximum and
// writes back Q(s,a) + alpha*(r + gamma*max - Q(s,a)), saturated to Q_WIDTH.
module q_update #(
  parameter int Q_WIDTH     = 8,
  parameter int STATE_WIDTH = 18,
  parameter int ACT_WIDTH   = 4,
  parameter int N_ACTIONS   = 9,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [STATE_WIDTH-1:0]    state,
  input  logic [ACT_WIDTH-1:0]      action,
  input  logic signed [Q_WIDTH-1:0] reward,
  input  logic [STATE_WIDTH-1:0]    next_state,
  input  logic                      terminal,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      mem_rd_en,
  output logic [STATE_WIDTH-1:0]    mem_rd_state,
  output logic [ACT_WIDTH-1:0]      mem_rd_action,
  input  logic signed [Q_WIDTH-1:0] mem_rd_data,
  output logic                      mem_wr_en,
  output logic [STATE_WIDTH-1:0]    mem_wr_state,
  output logic [ACT_WIDTH-1:0]      mem_wr_action,
  output logic signed [Q_WIDTH-1:0] mem_wr_data
);

  localparam int W1 = Q_WIDTH + 1;
  localparam int W2 = Q_WIDTH + 2;
  localparam int W3 = Q_WIDTH + 3;
  localparam int W4 = Q_WIDTH + 4;
  localparam logic [ACT_WIDTH-1:0] LAST_ACT = ACT_WIDTH'(N_ACTIONS - 1);
  localparam logic signed [W4-1:0] SAT_HI = W4'((1 << (Q_WIDTH - 1)) - 1);
  localparam logic signed [W4-1:0] SAT_LO = W4'(-(1 << (Q_WIDTH - 1)));

  typedef enum logic [2:0] {S_IDLE, S_RD_CUR, S_SCAN, S_DRAIN, S_WRITE} fsm_e;

  fsm_e                      fsm_q;
  logic [STATE_WIDTH-1:0]    state_q, next_state_q;
  logic [ACT_WIDTH-1:0]      action_q, cnt_q;
  logic signed [Q_WIDTH-1:0] reward_q, q_cur_q, q_max_q;
  logic                      terminal_q;

  // Values folded in during DRAIN: the last read reply lands in that cycle.
  logic signed [Q_WIDTH-1:0] q_cur_d, q_max_d, new_d;
  logic signed [W1-1:0]      q_max_x, g;
  logic signed [W2-1:0]      target;
  logic signed [W3-1:0]      delta, step;
  logic signed [W4-1:0]      sum;

  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    q_cur_d = terminal_q ? mem_rd_data : q_cur_q;
    if (terminal_q)
      q_max_d = '0;
    else if (cnt_q == '0)
      q_max_d = mem_rd_data;
    else
      q_max_d = (mem_rd_data > q_max_q) ? mem_rd_data : q_max_q;

    q_max_x = W1'(q_max_d);
    g       = q_max_x - (q_max_x >>> GAMMA_SHIFT);
    target  = W2'(reward_q) + W2'(g);
    delta   = W3'(target) - W3'(q_cur_d);
    step    = delta >>> ALPHA_SHIFT;
    sum     = W4'(q_cur_d) + W4'(step);

    if (sum > SAT_HI)
      new_d = SAT_HI[Q_WIDTH-1:0];
    else if (sum < SAT_LO)
      new_d = SAT_LO[Q_WIDTH-1:0];
    else
      new_d = sum[Q_WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking (<=) so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q         <= S_IDLE;
      state_q       <= '0;
      next_state_q  <= '0;
      action_q      <= '0;
      reward_q      <= '0;
      terminal_q    <= 1'b0;
      cnt_q         <= '0;
      q_cur_q       <= '0;
      q_max_q       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_rd_state  <= '0;
      mem_rd_action <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_state  <= '0;
      mem_wr_action <= '0;
      mem_wr_data   <= '0;
    end else begin
      done          <= 1'b0;
      err           <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_rd_state  <= '0;
      mem_rd_action <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_state  <= '0;
      mem_wr_action <= '0;
      mem_wr_data   <= '0;

      unique case (fsm_q)
        S_IDLE: begin
          if (start && action <= LAST_ACT) begin
            state_q       <= state;
            action_q      <= action;
            reward_q      <= reward;
            next_state_q  <= next_state;
            terminal_q    <= terminal;
            busy          <= 1'b1;
            mem_rd_en     <= 1'b1;
            mem_rd_state  <= state;
            mem_rd_action <= action;
            fsm_q         <= S_RD_CUR;
          end else if (start) begin
            err <= 1'b1;
          end
        end

        S_RD_CUR: begin
          cnt_q <= '0;
          if (terminal_q) begin
            fsm_q <= S_DRAIN;
          end else begin
            mem_rd_en     <= 1'b1;
            mem_rd_state  <= next_state_q;
            mem_rd_action <= '0;
            fsm_q         <= S_SCAN;
          end
        end

        // Reply in this cycle belongs to the read issued one cycle earlier.
        S_SCAN: begin
          if (cnt_q == '0)
            q_cur_q <= mem_rd_data;
          else if (cnt_q == ACT_WIDTH'(1))
            q_max_q <= mem_rd_data;
          else if (mem_rd_data > q_max_q)
            q_max_q <= mem_rd_data;

          if (cnt_q == LAST_ACT) begin
            fsm_q <= S_DRAIN;
          end else begin
            cnt_q         <= cnt_q + ACT_WIDTH'(1);
            mem_rd_en     <= 1'b1;
            mem_rd_state  <= next_state_q;
            mem_rd_action <= cnt_q + ACT_WIDTH'(1);
          end
        end

        S_DRAIN: begin
          q_cur_q       <= q_cur_d;
          q_max_q       <= q_max_d;
          mem_wr_en     <= 1'b1;
          mem_wr_state  <= state_q;
          mem_wr_action <= action_q;
          mem_wr_data   <= new_d;
          done          <= 1'b1;
          fsm_q         <= S_WRITE;
        end

        S_WRITE: begin
          busy  <= 1'b0;
          fsm_q <= S_IDLE;
        end

        default: fsm_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_update.sv
// Self-checking bench for q_update: directed vector table, handshake/reset
// sequences, and randomized updates against a behavioural TD-update model.
`timescale 1ns/1ps
module tb_q_update;

  localparam int QW = 8;
  localparam int SW = 18;
  localparam int AW = 4;
  localparam int NA = 9;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 terminal = 1'b0;
  logic [SW-1:0]        state = '0;
  logic [SW-1:0]        next_state = '0;
  logic [AW-1:0]        action = '0;
  logic signed [QW-1:0] reward = '0;
  logic signed [QW-1:0] mem_rd_data = '0;
  logic                 busy, done, err, mem_rd_en, mem_wr_en;
  logic [SW-1:0]        mem_rd_state, mem_wr_state;
  logic [AW-1:0]        mem_rd_action, mem_wr_action;
  logic signed [QW-1:0] mem_wr_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  q_update #(
    .Q_WIDTH(QW), .STATE_WIDTH(SW), .ACT_WIDTH(AW),
    .N_ACTIONS(NA), .ALPHA_SHIFT(2), .GAMMA_SHIFT(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .state(state), .action(action),
    .reward(reward), .next_state(next_state), .terminal(terminal),
    .busy(busy), .done(done), .err(err),
    .mem_rd_en(mem_rd_en), .mem_rd_state(mem_rd_state),
    .mem_rd_action(mem_rd_action), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_state(mem_wr_state),
    .mem_wr_action(mem_wr_action), .mem_wr_data(mem_wr_data)
  );

  // Q-table model: 1-cycle read latency, garbage on the bus when not reading.
  byte qmem [bit [21:0]];

  function automatic bit [21:0] key(int s, int a);
    return {s[17:0], a[3:0]};
  endfunction

  function automatic byte rd_mem(int s, int a);
    return qmem.exists(key(s, a)) ? qmem[key(s, a)] : 8'sd0;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= rd_mem(int'(mem_rd_state), int'(mem_rd_action));
    else           mem_rd_data <= QW'($urandom);
  end

  // Event log sampled mid-cycle.
  typedef struct { int cyc; int st; int act; int data; } ev_t;
  ev_t rd_log[$];
  ev_t wr_log[$];
  int  done_log[$];
  int  err_log[$];
  bit  busy_at[int];

  always @(negedge clk) begin
    ev_t e;
    if (mem_rd_en) begin
      e.cyc = cyc; e.st = int'(mem_rd_state); e.act = int'(mem_rd_action); e.data = 0;
      rd_log.push_back(e);
    end
    if (mem_wr_en) begin
      e.cyc = cyc; e.st = int'(mem_wr_state); e.act = int'(mem_wr_action); e.data = int'(mem_wr_data);
      wr_log.push_back(e);
    end
    if (done) done_log.push_back(cyc);
    if (err)  err_log.push_back(cyc);
    busy_at[cyc] = busy;
  end

  task automatic check(string name, longint actual, longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: Q += (r + 3/4*max - Q)/4 with floor division, clamped.
  function automatic int floor_div(int x, int d);
    return (x >= 0) ? x / d : -((-x + d - 1) / d);
  endfunction

  function automatic int model_new(int qcur, int r, bit term, input int qn[9]);
    int qmax, g, delta, n;
    qmax = 0;
    if (!term) begin
      qmax = qn[0];
      for (int k = 1; k < NA; k++) if (qn[k] > qmax) qmax = qn[k];
    end
    g     = qmax - floor_div(qmax, 4);
    delta = r + g - qcur;
    n     = qcur + floor_div(delta, 4);
    if (n > 127)  n = 127;
    if (n < -128) n = -128;
    return n;
  endfunction

  function automatic longint enc(int off, int st, int act);
    return (longint'(off) << 32) | (longint'(st) << 8) | longint'(act);
  endfunction

  function automatic int count_rd(int lo, int hi);
    int n = 0;
    foreach (rd_log[i]) if (rd_log[i].cyc >= lo && rd_log[i].cyc <= hi) n++;
    return n;
  endfunction

  function automatic int count_wr(int lo, int hi);
    int n = 0;
    foreach (wr_log[i]) if (wr_log[i].cyc >= lo && wr_log[i].cyc <= hi) n++;
    return n;
  endfunction

  function automatic int count_q(input int q[$], int lo, int hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
    return n;
  endfunction

  function automatic int count_busy(int lo, int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (busy_at.exists(c) && busy_at[c]) n++;
    return n;
  endfunction

  task automatic wait_until(int tgt);
    while (cyc < tgt) @(negedge clk);
  endtask

  task automatic preload(int s, int a, int s2, int qcur, input int qn[9]);
    qmem[key(s, a)] = byte'(qcur);
    for (int k = 0; k < NA; k++) qmem[key(s2, k)] = byte'(qn[k]);
  endtask

  task automatic launch(int s, int a, int r, int s2, bit term, output int t0);
    @(negedge clk);
    start      = 1'b1;
    state      = s[SW-1:0];
    action     = a[AW-1:0];
    reward     = r[QW-1:0];
    next_state = s2[SW-1:0];
    terminal   = term;
    t0         = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_update(string name, int t0, int s, int a, int s2, bit term, int exp_new);
    int     len, hi;
    longint exp_rd[$];
    longint got_rd[$];
    longint got_wr[$];
    int     wr_dat[$];
    int     dn[$];
    len = term ? 3 : 12;
    hi  = t0 + len + 1;
    exp_rd.push_back(enc(1, s, a));
    if (!term) for (int k = 0; k < NA; k++) exp_rd.push_back(enc(2 + k, s2, k));
    foreach (rd_log[i])
      if (rd_log[i].cyc >= t0 && rd_log[i].cyc <= hi)
        got_rd.push_back(enc(rd_log[i].cyc - t0, rd_log[i].st, rd_log[i].act));
    foreach (wr_log[i])
      if (wr_log[i].cyc >= t0 && wr_log[i].cyc <= hi) begin
        got_wr.push_back(enc(wr_log[i].cyc - t0, wr_log[i].st, wr_log[i].act));
        wr_dat.push_back(wr_log[i].data);
      end
    foreach (done_log[i]) if (done_log[i] >= t0 && done_log[i] <= hi) dn.push_back(done_log[i] - t0);

    check({name, " read count"}, got_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++)
      check($sformatf("%s read%0d cyc/addr", name, i), (i < got_rd.size()) ? got_rd[i] : -1, exp_rd[i]);
    check({name, " write count"}, got_wr.size(), 1);
    check({name, " write cyc/addr"}, (got_wr.size() > 0) ? got_wr[0] : -1, enc(len, s, a));
    check({name, " write data"}, (wr_dat.size() > 0) ? wr_dat[0] : 9999, exp_new);
    check({name, " done count"}, dn.size(), 1);
    check({name, " done cycle"}, (dn.size() > 0) ? dn[0] : -1, len);
    check({name, " busy cycles"}, count_busy(t0 + 1, t0 + len), len);
    check({name, " busy low after"}, count_busy(hi, hi), 0);
    check({name, " no err"}, count_q(err_log, t0, hi), 0);
  endtask

  task automatic do_update(string name, int s, int a, int s2, bit term, int r, int qcur,
                           input int qn[9], int exp_new);
    int t0;
    preload(s, a, s2, qcur, qn);
    launch(s, a, r, s2, term, t0);
    wait_until(t0 + (term ? 3 : 12) + 2);
    check_update(name, t0, s, a, s2, term, exp_new);
  endtask

  function automatic int rnd_q();
    case ($urandom_range(0, 5))
      0:       return -128;
      1:       return 127;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  typedef struct {
    bit               term;
    int               qcur;
    int               rew;
    logic [0:8][7:0]  qn;
    int               exp_new;
  } vec_t;

  vec_t vecs[8];
  int   qv1[9];
  int   qv5[9];

  initial begin
    int t0, t1;

    vecs[0] = '{1'b1,    0,   64, {9{8'h00}}, 16};
    vecs[1] = '{1'b0,   10,    0, {8'd5, 8'd40, 8'hFD, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7}, 15};
    vecs[2] = '{1'b0,    0,    0, {8'hCE, 8'hCE, 8'hCE, 8'hCE, 8'hCE, 8'hCE, 8'hEC, 8'hCE, 8'hCE}, -4};
    vecs[3] = '{1'b0,  127,  127, {9{8'd127}}, 127};
    vecs[4] = '{1'b1, -128, -128, {9{8'h00}}, -128};
    vecs[5] = '{1'b0,    0,    0, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd100}, 18};
    vecs[6] = '{1'b0,    0,    0, {8'd20, 8'hFF, 8'h80, 8'hF9, 8'h9C, 8'hFE, 8'hFD, 8'hFC, 8'hFB}, 3};
    vecs[7] = '{1'b0, -128, -128, {9{8'h80}}, -128};
    for (int k = 0; k < NA; k++) begin
      qv1[k] = int'($signed(vecs[1].qn[k]));
      qv5[k] = int'($signed(vecs[5].qn[k]));
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset rd_en", mem_rd_en, 0);
    check("reset rd_addr", {mem_rd_state, mem_rd_action}, 0);
    check("reset wr_en", mem_wr_en, 0);
    check("reset wr_addr", {mem_wr_state, mem_wr_action}, 0);
    check("reset wr_data", mem_wr_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      int qn[9];
      for (int k = 0; k < NA; k++) qn[k] = int'($signed(vecs[i].qn[k]));
      do_update($sformatf("vec%0d", i), 1000 + 7 * i, i % NA, 5000 + 11 * i,
                vecs[i].term, vecs[i].rew, vecs[i].qcur, qn, vecs[i].exp_new);
    end

    // Illegal action: err pulse only
    launch(2000, 9, 5, 2001, 1'b0, t0);
    wait_until(t0 + 6);
    check("illegal err count", count_q(err_log, t0, t0 + 5), 1);
    check("illegal err cycle", count_q(err_log, t0 + 1, t0 + 1), 1);
    check("illegal reads", count_rd(t0, t0 + 5), 0);
    check("illegal writes", count_wr(t0, t0 + 5), 0);
    check("illegal busy", count_busy(t0, t0 + 5), 0);

    // start during SCAN (c5) is ignored
    preload(3000, 4, 3100, 10, qv1);
    launch(3000, 4, 0, 3100, 1'b0, t0);
    wait_until(t0 + 5);
    start = 1'b1; state = 18'd3200; action = 4'd2; next_state = 18'd3300; terminal = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 19);
    check_update("midstart", t0, 3000, 4, 3100, 1'b0, 15);
    check("midstart quiet reads", count_rd(t0 + 13, t0 + 18), 0);
    check("midstart quiet writes", count_wr(t0 + 13, t0 + 18), 0);

    // Back-to-back: second start at c13 is accepted
    preload(4000, 7, 4100, 10, qv1);
    launch(4000, 7, 0, 4100, 1'b0, t0);
    wait_until(t0 + 12);
    preload(4200, 1, 4300, 0, qv5);
    launch(4200, 1, 0, 4300, 1'b0, t1);
    wait_until(t1 + 14);
    check_update("b2b first", t0, 4000, 7, 4100, 1'b0, 15);
    check_update("b2b second", t1, 4200, 1, 4300, 1'b0, 18);

    // Reset at c6 aborts the update without a write
    preload(6000, 3, 6100, 10, qv1);
    launch(6000, 3, 0, 6100, 1'b0, t0);
    wait_until(t0 + 6);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", busy, 0);
    check("midrst rd_en", mem_rd_en, 0);
    check("midrst rd_addr", {mem_rd_state, mem_rd_action}, 0);
    check("midrst wr_en", mem_wr_en, 0);
    check("midrst done", done, 0);
    rst = 1'b0;
    wait_until(t0 + 22);
    check("midrst no writes", count_wr(t0 + 7, t0 + 21), 0);
    check("midrst no reads", count_rd(t0 + 7, t0 + 21), 0);
    check("midrst no done", count_q(done_log, t0 + 7, t0 + 21), 0);
    do_update("after rst", 6000, 3, 6100, 1'b0, 0, 10, qv1, 15);

    // Randomized updates against the model
    for (int n = 0; n < 40; n++) begin
      int s, s2, a, r, qc, e;
      int qn[9];
      bit t;
      s  = int'($urandom_range(0, (1 << SW) - 1));
      s2 = s ^ int'($urandom_range(1, (1 << SW) - 1));
      a  = int'($urandom_range(0, NA - 1));
      r  = rnd_q();
      qc = rnd_q();
      t  = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NA; k++) qn[k] = rnd_q();
      e = model_new(qc, r, t, qn);
      do_update($sformatf("rand%0d", n), s, a, s2, t, r, qc, qn, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
